// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX and TX controllers.
//   - State encoding for the RX controller FSM.
//   - Parity-mode constants.
package uart_pkg;

    // RX controller state encoding.
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = IDLE,
        StStart  = START,
        StData   = DATA,
        StParity = PARITY,
        StStop   = STOP
    } rx_state_e;

    // Parity modes, shared with the transmitter.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_os_counter.sv
// Oversample counter: advances on each tick, synchronous clear has priority,
// and flags the tick on which the count equals a programmable terminal value.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-low reset
//   tick     - count enable (baud_tick)
//   clear    - synchronous clear to zero
//   terminal - terminal count to compare against
//   hit      - tick taken while count == terminal (combinational)
module uart_os_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clear,
    input  logic [WIDTH-1:0] terminal,
    output logic             hit
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (tick) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign hit = tick && (count_q == terminal);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller. Qualifies the start bit at mid-bit, samples data
// (LSB first), optional parity and stop bit at the end of each oversampled bit
// period, and reports the received word with parity / framing status.
// Ports:
//   clk, rst       - clock, asynchronous active-low reset
//   baud_tick      - oversample enable
//   rx_in          - synchronized serial line (idle high)
//   rx_data        - last received word
//   rx_valid       - one-cycle frame-complete pulse
//   parity_err     - parity mismatch on last frame (held)
//   framing_err    - stop bit sampled low on last frame (held)
//   busy           - controller not idle
//   shift_bit      - strobe per sampled data bit
//   parity_load    - strobe when the parity bit is sampled
//   check_stop     - strobe when the stop bit is sampled
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 busy,
    output logic                 shift_bit,
    output logic                 parity_load,
    output logic                 check_stop
);

    localparam int unsigned OsW  = $clog2(OVERSAMPLE);
    localparam int unsigned BitW = $clog2(DATA_BITS + 1);

    localparam logic [OsW-1:0]  MidTerm = OsW'(OVERSAMPLE / 2 - 1);
    localparam logic [OsW-1:0]  EndTerm = OsW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);
    localparam logic            OddMode = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    rx_state_e            state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [BitW-1:0]      bit_cnt_q;
    logic                 par_acc_q;   // running XOR of data bits
    logic                 par_pend_q;  // parity result waiting for the stop bit

    logic           os_clear;
    logic [OsW-1:0] os_term;
    logic           sample;

    // Holding the counter cleared while idle means the detection tick starts
    // the start bit from zero; every sample restarts the bit period.
    assign os_clear = (state_q == StIdle) || sample;
    assign os_term  = (state_q == StStart) ? MidTerm : EndTerm;

    uart_os_counter #(
        .WIDTH (OsW)
    ) u_os_cnt (
        .clk      (clk),
        .rst      (rst),
        .tick     (baud_tick),
        .clear    (os_clear),
        .terminal (os_term),
        .hit      (sample)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            par_acc_q   <= 1'b0;
            par_pend_q  <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            busy        <= 1'b0;
            shift_bit   <= 1'b0;
            parity_load <= 1'b0;
            check_stop  <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            shift_bit   <= 1'b0;
            parity_load <= 1'b0;
            check_stop  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (baud_tick && !rx_in) begin
                        state_q <= StStart;
                        busy    <= 1'b1;
                    end
                end
                StStart: begin
                    if (sample) begin
                        if (rx_in) begin
                            // Glitch: drop back silently, error flags untouched.
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end else begin
                            state_q    <= StData;
                            bit_cnt_q  <= '0;
                            par_acc_q  <= 1'b0;
                            par_pend_q <= 1'b0;
                        end
                    end
                end
                StData: begin
                    if (sample) begin
                        shift_q   <= {rx_in, shift_q[DATA_BITS-1:1]};
                        par_acc_q <= par_acc_q ^ rx_in;
                        shift_bit <= 1'b1;
                        bit_cnt_q <= bit_cnt_q + BitW'(1);
                        if (bit_cnt_q == LastBit) begin
                            state_q <= (PARITY_EN != 0) ? StParity : StStop;
                        end
                    end
                end
                StParity: begin
                    if (sample) begin
                        parity_load <= 1'b1;
                        par_pend_q  <= (par_acc_q ^ rx_in) != OddMode;
                        state_q     <= StStop;
                    end
                end
                StStop: begin
                    if (sample) begin
                        check_stop  <= 1'b1;
                        rx_valid    <= 1'b1;
                        rx_data     <= shift_q;
                        parity_err  <= par_pend_q;
                        framing_err <= ~rx_in;
                        busy        <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: one 8E1 instance (index 0) and one 8N1 instance
// (index 1), both 16x. Line levels are recorded per tick; a reference decoder
// walks that history using the frame timing rules and predicts every frame.
module tb_uart_rx_ctrl;

    localparam int OS   = 16;
    localparam int NB   = 8;
    localparam int MAXT = 16384;

    typedef struct {
        int         tick;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic baud_tick = 1'b0;

    logic       rx_line     [2];
    logic [7:0] rx_data     [2];
    logic       rx_valid    [2];
    logic       parity_err  [2];
    logic       framing_err [2];
    logic       busy        [2];
    logic       shift_bit   [2];
    logic       parity_load [2];
    logic       check_stop  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        uart_rx_ctrl #(
            .DATA_BITS  (NB),
            .OVERSAMPLE (OS),
            .PARITY_EN  ((g == 0) ? 1 : 0),
            .PARITY_ODD (0)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .baud_tick   (baud_tick),
            .rx_in       (rx_line[g]),
            .rx_data     (rx_data[g]),
            .rx_valid    (rx_valid[g]),
            .parity_err  (parity_err[g]),
            .framing_err (framing_err[g]),
            .busy        (busy[g]),
            .shift_bit   (shift_bit[g]),
            .parity_load (parity_load[g]),
            .check_stop  (check_stop[g])
        );
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    logic hist [2][MAXT];
    int   nt          = 0;
    int   applied_idx = -1;
    logic wave  [2][$];
    ev_t  got_q [2][$];
    ev_t  exp_q [2][$];
    int   got_sb [2], got_pl [2], got_cs [2];
    int   exp_sb [2], exp_pl [2], exp_cs [2];
    logic busy_seen [2];

    task automatic check_eq(input string tag, input logic [31:0] got_v,
                            input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    task automatic add_level(input int w, input logic lvl, input int cnt);
        for (int i = 0; i < cnt; i++) wave[w].push_back(lvl);
    endtask

    task automatic add_frame(input int w, input logic [7:0] d, input bit flip,
                             input logic stop, input int stop_len, input int gap);
        add_level(w, 1'b0, OS);
        for (int k = 0; k < NB; k++) add_level(w, d[k], OS);
        if (w == 0) add_level(w, (^d) ^ flip, OS);
        add_level(w, stop, stop_len);
        add_level(w, 1'b1, gap);
    endtask

    // Reference decoder over the recorded tick history of one line.
    function automatic void model(input int w, input int n);
        int         t, s, tk, pe;
        logic [7:0] d;
        logic       perr;
        bit         abort;
        ev_t        e;
        pe = (w == 0) ? 1 : 0;
        t  = 0;
        while (t < n) begin
            if (hist[w][t] !== 1'b0) begin
                t++;
                continue;
            end
            s = t + OS / 2;
            if (s >= n) break;
            if (hist[w][s]) begin
                t = s + 1;
                continue;
            end
            d = '0; perr = 1'b0; abort = 1'b0; tk = s;
            for (int k = 0; k < NB; k++) begin
                tk = s + OS * (k + 1);
                if (tk >= n) begin
                    abort = 1'b1;
                    break;
                end
                d[k] = hist[w][tk];
                exp_sb[w]++;
            end
            if (!abort && pe == 1) begin
                tk = s + OS * (NB + 1);
                if (tk >= n) abort = 1'b1;
                else begin
                    exp_pl[w]++;
                    perr = ((^d) ^ hist[w][tk]) != 1'b0;
                end
            end
            if (!abort) begin
                tk = s + OS * (NB + pe + 1);
                if (tk >= n) abort = 1'b1;
                else begin
                    exp_cs[w]++;
                    e.tick = tk; e.data = d; e.perr = perr; e.ferr = ~hist[w][tk];
                    exp_q[w].push_back(e);
                end
            end
            if (abort) break;
            t = tk + 1;
        end
    endfunction

    task automatic observe();
        ev_t e;
        for (int w = 0; w < 2; w++) begin
            if (shift_bit[w])   got_sb[w]++;
            if (parity_load[w]) got_pl[w]++;
            if (check_stop[w])  got_cs[w]++;
            if (busy[w])        busy_seen[w] = 1'b1;
            if (rx_valid[w]) begin
                e.tick = applied_idx; e.data = rx_data[w];
                e.perr = parity_err[w]; e.ferr = framing_err[w];
                got_q[w].push_back(e);
                check_eq($sformatf("w%0d_stop_with_valid", w), 32'(check_stop[w]), 32'd1);
                check_eq($sformatf("w%0d_busy_falls", w), 32'(busy[w]), 32'd0);
            end
        end
    endtask

    task automatic step(input logic tk);
        @(negedge clk);
        observe();
        baud_tick = tk;
        if (tk) begin
            if (nt >= MAXT) begin
                $display("FAIL tick_budget: got %0d ticks, limit %0d", nt, MAXT);
                $fatal(1, "tick history overflow");
            end
            for (int w = 0; w < 2; w++) begin
                rx_line[w] = (wave[w].size() > 0) ? wave[w].pop_front() : 1'b1;
                hist[w][nt] = rx_line[w];
            end
            applied_idx = nt;
            nt++;
        end else begin
            applied_idx = -1;
        end
    endtask

    task automatic run_phase(input int density, input int max_ticks);
        while ((wave[0].size() > 0 || wave[1].size() > 0) && nt < max_ticks) begin
            while ($urandom_range(99) >= density) step(1'b0);
            step(1'b1);
        end
        step(1'b0);
        step(1'b0);
    endtask

    task automatic check_event(input string tag, input int w, input int i, input int tick,
                               input logic [7:0] d, input logic pe, input logic fe);
        if (got_q[w].size() <= i) begin
            check_eq({tag, "_present"}, 32'(got_q[w].size()), 32'(i + 1));
        end else begin
            check_eq({tag, "_tick"}, 32'(got_q[w][i].tick), 32'(tick));
            check_eq({tag, "_data"}, 32'(got_q[w][i].data), 32'(d));
            check_eq({tag, "_perr"}, 32'(got_q[w][i].perr), 32'(pe));
            check_eq({tag, "_ferr"}, 32'(got_q[w][i].ferr), 32'(fe));
        end
    endtask

    task automatic finish_phase(input string name);
        int m;
        for (int w = 0; w < 2; w++) begin
            model(w, nt);
            check_eq($sformatf("%s_w%0d_frames", name, w), 32'(got_q[w].size()),
                     32'(exp_q[w].size()));
            check_eq($sformatf("%s_w%0d_shift", name, w), 32'(got_sb[w]), 32'(exp_sb[w]));
            check_eq($sformatf("%s_w%0d_parity", name, w), 32'(got_pl[w]), 32'(exp_pl[w]));
            check_eq($sformatf("%s_w%0d_stop", name, w), 32'(got_cs[w]), 32'(exp_cs[w]));
            m = (got_q[w].size() < exp_q[w].size()) ? got_q[w].size() : exp_q[w].size();
            for (int i = 0; i < m; i++) begin
                check_eq($sformatf("%s_w%0d_f%0d_tick", name, w, i),
                         32'(got_q[w][i].tick), 32'(exp_q[w][i].tick));
                check_eq($sformatf("%s_w%0d_f%0d_data", name, w, i),
                         32'(got_q[w][i].data), 32'(exp_q[w][i].data));
                check_eq($sformatf("%s_w%0d_f%0d_perr", name, w, i),
                         32'(got_q[w][i].perr), 32'(exp_q[w][i].perr));
                check_eq($sformatf("%s_w%0d_f%0d_ferr", name, w, i),
                         32'(got_q[w][i].ferr), 32'(exp_q[w][i].ferr));
            end
            got_q[w].delete(); exp_q[w].delete(); wave[w].delete();
            got_sb[w] = 0; got_pl[w] = 0; got_cs[w] = 0;
            exp_sb[w] = 0; exp_pl[w] = 0; exp_cs[w] = 0;
            busy_seen[w] = 1'b0;
        end
        nt = 0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int w = 0; w < 2; w++) begin
            check_eq($sformatf("%s_w%0d", tag, w),
                     32'({rx_data[w], rx_valid[w], parity_err[w], framing_err[w], busy[w],
                          shift_bit[w], parity_load[w], check_stop[w]}), 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        for (int w = 0; w < 2; w++) begin
            rx_line[w] = 1'b1;
            got_sb[w] = 0; got_pl[w] = 0; got_cs[w] = 0;
            exp_sb[w] = 0; exp_pl[w] = 0; exp_cs[w] = 0;
            busy_seen[w] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        @(negedge clk);
        rst = 1'b1;

        // 8E1 0xA5; 8N1 back-to-back 0x55 / 0xFF.
        add_frame(0, 8'hA5, 1'b0, 1'b1, OS, 40);
        add_frame(1, 8'h55, 1'b0, 1'b1, OS, 0);
        add_frame(1, 8'hFF, 1'b0, 1'b1, OS, 40);
        run_phase(100, MAXT);
        check_event("a5", 0, 0, 168, 8'hA5, 1'b0, 1'b0);
        check_event("b2b_55", 1, 0, 152, 8'h55, 1'b0, 1'b0);
        check_event("b2b_ff", 1, 1, 312, 8'hFF, 1'b0, 1'b0);
        finish_phase("directed");

        // Start glitch: low 4 ticks then high.
        for (int w = 0; w < 2; w++) begin
            add_level(w, 1'b0, 4);
            add_level(w, 1'b1, 5);
        end
        run_phase(100, MAXT);
        for (int w = 0; w < 2; w++) begin
            check_eq($sformatf("glitch_w%0d_busy_seen", w), 32'(busy_seen[w]), 32'd1);
            check_eq($sformatf("glitch_w%0d_busy_low", w), 32'(busy[w]), 32'd0);
        end
        finish_phase("glitch");

        // Bad parity on 8E1; bad stop on 8N1.
        add_frame(0, 8'h3C, 1'b1, 1'b1, OS, 40);
        add_frame(1, 8'h3C, 1'b0, 1'b0, OS, 40);
        run_phase(100, MAXT);
        check_event("badpar", 0, 0, 168, 8'h3C, 1'b1, 1'b0);
        check_event("badstop", 1, 0, 152, 8'h3C, 1'b0, 1'b1);
        finish_phase("errors");

        // Break: line low for 200 ticks, then the frame restarts at once.
        for (int w = 0; w < 2; w++) begin
            add_level(w, 1'b0, 200);
            add_level(w, 1'b1, 400);
        end
        run_phase(100, MAXT);
        check_event("brk_e0", 0, 0, 168, 8'h00, 1'b0, 1'b1);
        check_event("brk_e1", 0, 1, 337, 8'hFE, 1'b0, 1'b0);
        check_event("brk_n0", 1, 0, 152, 8'h00, 1'b0, 1'b1);
        check_event("brk_n1", 1, 1, 305, 8'hFC, 1'b0, 1'b0);
        finish_phase("break");

        // Reset after data bit 3 has been sampled (tick 72).
        add_frame(0, 8'h5A, 1'b0, 1'b1, OS, 40);
        add_frame(1, 8'h5A, 1'b0, 1'b1, OS, 40);
        run_phase(100, 76);
        @(negedge clk);
        for (int w = 0; w < 2; w++)
            check_eq($sformatf("pre_reset_w%0d_busy", w), 32'(busy[w]), 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("reset_mid");
        finish_phase("reset_mid");
        @(negedge clk);
        rst = 1'b1;
        add_frame(0, 8'hC3, 1'b0, 1'b1, OS, 40);
        add_frame(1, 8'h81, 1'b0, 1'b1, OS, 40);
        run_phase(100, MAXT);
        check_event("post_rst_e", 0, 0, 168, 8'hC3, 1'b0, 1'b0);
        check_event("post_rst_n", 1, 0, 152, 8'h81, 1'b0, 1'b0);
        finish_phase("post_reset");

        // Random frames, errors, glitches, short stop bits and sparse ticks.
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 25; i++) begin
                if ($urandom_range(7) == 0) begin
                    add_level(w, 1'b0, $urandom_range(OS / 2, 1));
                    add_level(w, 1'b1, $urandom_range(OS, 1));
                end
                add_frame(w, 8'($urandom_range(255)), $urandom_range(5) == 0,
                          $urandom_range(5) != 0,
                          ($urandom_range(3) == 0) ? OS / 2 + 1 : OS,
                          $urandom_range(20));
            end
            add_level(w, 1'b1, 2 * OS);
        end
        run_phase(50, MAXT);
        finish_phase("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
